regfile_write_arbiter: RTL and testbench

Shares the single register-file write port (WriteEnable/WriteAddress/WriteData) between two writeback requesters: requester 0 is the ALU writeback and requester 1 is the load/immediate path. Arbitration is round-robin, with bounded bursts so that one owner can keep the port for consecutive writes. The granted write is registered and presented to the register file one cycle later. The block sits directly in front of the register file and is the only driver of its write port.

---
 rtl/rf_arb_pkg.sv | 14 +
 rtl/rf_arb_burst_ctr.sv | 35 +++
 rtl/regfile_write_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file write arbiter.
package rf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int BURST_W    = 4;

endpackage

// File: rtl/rf_arb_burst_ctr.sv
// Saturating burst counter: counts consecutive grants to the current owner.
module rf_arb_burst_ctr
  import rf_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load_one,
  input  logic incr,
  output logic at_max
);

  logic [BURST_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load_one) begin
      cnt_d = BURST_W'(1);
    end else if (incr && (cnt_q < BURST_W'(MAX_BURST))) begin
      cnt_d = cnt_q + BURST_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign at_max = (cnt_q >= BURST_W'(MAX_BURST));

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin, burst-bounded arbiter for the register-file write port.
// Optional RF_ARB_R0_ZERO_EN: writes to register 0 are granted but suppressed.
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Req0,
  input  logic              Req1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] Data0,
  input  logic [DATA_W-1:0] Data1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              WriteEnable,
  output logic [ADDR_W-1:0] WriteAddress,
  output logic [DATA_W-1:0] WriteData,
  output logic              Owner
);

  arb_state_e        state_d, state_q;
  logic              last_gnt_d, last_gnt_q;
  logic              we_d, we_q;
  logic [ADDR_W-1:0] waddr_d, waddr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic              burst_clear, burst_load, burst_incr, burst_at_max;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              wr_allowed;

  rf_arb_burst_ctr #(.MAX_BURST(MAX_BURST)) u_burst (
    .clk      (CLK),
    .rst      (RST),
    .clear    (burst_clear),
    .load_one (burst_load),
    .incr     (burst_incr),
    .at_max   (burst_at_max)
  );

  // Grants are suppressed entirely while reset is asserted.
  always_comb begin
    state_d     = state_q;
    Gnt0        = 1'b0;
    Gnt1        = 1'b0;
    burst_clear = 1'b0;
    burst_load  = 1'b0;
    burst_incr  = 1'b0;
    if (!RST) begin
      unique case (state_q)
        IDLE: begin
          if (Req0 && (!Req1 || last_gnt_q)) begin
            Gnt0 = 1'b1; state_d = OWN0; burst_load = 1'b1;
          end else if (Req1) begin
            Gnt1 = 1'b1; state_d = OWN1; burst_load = 1'b1;
          end
        end
        OWN0: begin
          if (Req0 && !(Req1 && burst_at_max)) begin
            Gnt0 = 1'b1; burst_incr = 1'b1;
          end else if (Req1) begin
            Gnt1 = 1'b1; state_d = OWN1; burst_load = 1'b1;
          end else begin
            state_d = IDLE; burst_clear = 1'b1;
          end
        end
        OWN1: begin
          if (Req1 && !(Req0 && burst_at_max)) begin
            Gnt1 = 1'b1; burst_incr = 1'b1;
          end else if (Req0) begin
            Gnt0 = 1'b1; state_d = OWN0; burst_load = 1'b1;
          end else begin
            state_d = IDLE; burst_clear = 1'b1;
          end
        end
        default: begin
          state_d = IDLE; burst_clear = 1'b1;
        end
      endcase
    end
  end

  assign sel_addr = Gnt1 ? Addr1 : Addr0;
  assign sel_data = Gnt1 ? Data1 : Data0;

`ifdef RF_ARB_R0_ZERO_EN
  assign wr_allowed = (sel_addr != '0);
`else
  assign wr_allowed = 1'b1;
`endif

  always_comb begin
    last_gnt_d = last_gnt_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (Gnt0 || Gnt1) begin
      last_gnt_d = Gnt1;
      we_d       = wr_allowed;
      waddr_d    = sel_addr;
      wdata_d    = sel_data;
    end
  end

  // LastGnt resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign WriteEnable  = we_q;
  assign WriteAddress = waddr_q;
  assign WriteData    = wdata_q;
  assign Owner        = last_gnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter; honours RF_ARB_R0_ZERO_EN if defined.
module tb_regfile_write_arbiter;
  import rf_arb_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Req0 = 1'b0, Req1 = 1'b0;
  logic [3:0] Addr0 = '0, Addr1 = '0;
  logic [7:0] Data0 = '0, Data1 = '0;
  logic       Gnt0, Gnt1, WriteEnable, Owner;
  logic [3:0] WriteAddress;
  logic [7:0] WriteData;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  regfile_write_arbiter #(.DATA_W(8), .ADDR_W(4), .MAX_BURST(4)) dut (
    .CLK(CLK), .RST(RST),
    .Req0(Req0), .Req1(Req1),
    .Addr0(Addr0), .Addr1(Addr1),
    .Data0(Data0), .Data1(Data1),
    .Gnt0(Gnt0), .Gnt1(Gnt1),
    .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
    .WriteData(WriteData), .Owner(Owner)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_write(input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    e.cyc  = cyc + 1;
    e.addr = a;
    e.data = d;
`ifdef RF_ARB_R0_ZERO_EN
    if (a != 4'd0) exp_q.push_back(e);
`else
    exp_q.push_back(e);
`endif
  endtask

  // One cycle of stimulus: entered and left at posedge+1.
  task automatic apply_stimulus(input logic rst,
                                input logic r0, input logic [3:0] a0, input logic [7:0] d0,
                                input logic r1, input logic [3:0] a1, input logic [7:0] d1,
                                input logic eg0, input logic eg1, input string name);
    RST = rst; Req0 = r0; Addr0 = a0; Data0 = d0; Req1 = r1; Addr1 = a1; Data1 = d1;
    @(negedge CLK);
    check_output({name, "_gnt0"}, 32'(Gnt0), 32'(eg0));
    check_output({name, "_gnt1"}, 32'(Gnt1), 32'(eg1));
    if (eg0) push_write(a0, d0);
    else if (eg1) push_write(a1, d1);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycle(input string name);
    apply_stimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, name);
  endtask

  // Monitor: every cycle the write port must match the scoreboard head or be idle.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("wr_en", 32'(WriteEnable), 32'd1);
        check_output("wr_addr", 32'(WriteAddress), 32'(e.addr));
        check_output("wr_data", 32'(WriteData), 32'(e.data));
      end else begin
        check_output("wr_idle", 32'(WriteEnable), 32'd0);
      end
    end
  end

  initial begin
    @(posedge CLK);
    #1;
    mon_en = 1'b1;
    check_output("rst_waddr", 32'(WriteAddress), 32'd0);
    check_output("rst_wdata", 32'(WriteData), 32'd0);
    check_output("rst_owner", 32'(Owner), 32'd1);
    check_output("rst_state", 32'(dut.state_q), 32'(IDLE));

    // Requests during reset must not be granted.
    apply_stimulus(1'b1, 1'b1, 4'd5, 8'h11, 1'b1, 4'd6, 8'h22, 1'b0, 1'b0, "in_reset");

    // Single write, then idle.
    apply_stimulus(1'b0, 1'b1, 4'd3, 8'hA5, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, "single");
    idle_cycle("single_after");
    idle_cycle("single_after2");

    // Tie after reset: 0,0,0,0,1,1,1,1,0.
    apply_stimulus(1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, "tie_rst");
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b0, 1'b1, 4'd2, 8'h22, 1'b1, 4'd7, 8'h77,
                     (i < 4 || i == 8), (i >= 4 && i < 8), $sformatf("tie%0d", i));
    end
    check_output("tie_owner", 32'(Owner), 32'd0);
    idle_cycle("tie_after");

    // Unloaded burst on requester 1 never yields.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'(i), 8'(8'h30 + i),
                     1'b0, 1'b1, $sformatf("burst1_%0d", i));
    end
    check_output("burst_owner", 32'(Owner), 32'd1);
    idle_cycle("burst_after");

    // Handoff with no bubble.
    apply_stimulus(1'b0, 1'b1, 4'd4, 8'h40, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, "hand_a");
    apply_stimulus(1'b0, 1'b1, 4'd5, 8'h41, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, "hand_b");
    apply_stimulus(1'b0, 1'b0, 4'd5, 8'h41, 1'b1, 4'd9, 8'h90, 1'b0, 1'b1, "hand_n");
    check_output("hand_state", 32'(dut.state_q), 32'(OWN1));
    apply_stimulus(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'd10, 8'h91, 1'b0, 1'b1, "hand_n1");
    idle_cycle("hand_after");

    // Reset in the third cycle of an OWN0 burst.
    apply_stimulus(1'b0, 1'b1, 4'd6, 8'h60, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, "mid_1");
    apply_stimulus(1'b0, 1'b1, 4'd7, 8'h61, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, "mid_2");
    apply_stimulus(1'b1, 1'b1, 4'd8, 8'h62, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, "mid_rst");
    check_output("mid_waddr", 32'(WriteAddress), 32'd0);
    check_output("mid_wdata", 32'(WriteData), 32'd0);
    check_output("mid_state", 32'(dut.state_q), 32'(IDLE));
    check_output("mid_owner", 32'(Owner), 32'd1);
    apply_stimulus(1'b0, 1'b1, 4'd8, 8'h62, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, "mid_again");
    idle_cycle("mid_after");

    // Register-0 write followed by a normal write.
    apply_stimulus(1'b0, 1'b1, 4'd0, 8'hFF, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, "r0_write");
    apply_stimulus(1'b0, 1'b1, 4'd1, 8'h12, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, "r1_write");
    idle_cycle("r0_after");
    idle_cycle("drain");

    check_output("sb_empty", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
